// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage in-order core: forwarding selects,
// load-use / branch / memory-wait stalls and flushes, M-stage req/ack sequencing.
module hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1d,
  input  logic [4:0]       rs2d,
  input  logic [4:0]       rs1e,
  input  logic [4:0]       rs2e,
  input  logic [4:0]       rde,
  input  logic [1:0]       rsltSrce,
  input  logic             pcSrce,
  input  logic [4:0]       rdm,
  input  logic             regWrtm,
  input  logic             memRdm,
  input  logic             memWrtm,
  input  logic [4:0]       rdw,
  input  logic             regWrtw,
  input  logic             dAck,
  output logic             dReq,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [1:0]       fwdAe,
  output logic [1:0]       fwdBe,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCycles
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int             WCW      = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  state_t           state_r;
  state_t           stateNext_s;
  logic [WCW-1:0]   waitCnt_r;
  logic [WCW-1:0]   waitCntNext_s;
  logic             memOp_s;
  logic             memStall_s;
  logic             lwStall_s;

  // M-stage result has priority over W-stage; x0 is never forwarded.
  function automatic logic [1:0] fwdSel(
    input logic [4:0] src,
    input logic [4:0] rdM,
    input logic       wrM,
    input logic [4:0] rdW,
    input logic       wrW
  );
    logic [1:0] sel;
    if (wrM && (rdM != 5'd0) && (rdM == src)) begin
      sel = 2'b10;
    end else if (wrW && (rdW != 5'd0) && (rdW == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard detection and combinational stall/flush/forward outputs.
  always_comb begin
    memOp_s    = memRdm | memWrtm;
    memStall_s = memOp_s & ~dAck;
    lwStall_s  = (rsltSrce == 2'b01) && (rde != 5'd0) &&
                 ((rde == rs1d) || (rde == rs2d));
    dReq   = 1'b0;
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b1;
    flushE = 1'b1;
    flushW = 1'b1;
    fwdAe  = 2'b00;
    fwdBe  = 2'b00;
    if (rst) begin
      dReq = 1'b0;
    end else begin
      dReq   = memOp_s;
      fwdAe  = fwdSel(rs1e, rdm, regWrtm, rdw, regWrtw);
      fwdBe  = fwdSel(rs2e, rdm, regWrtm, rdw, regWrtw);
      // A memory freeze holds E intact so its branch/load acts on release.
      stallF = memStall_s | (lwStall_s & ~pcSrce);
      stallD = memStall_s | (lwStall_s & ~pcSrce);
      stallE = memStall_s;
      stallM = memStall_s;
      flushW = memStall_s;
      flushD = ~memStall_s & pcSrce;
      flushE = ~memStall_s & (pcSrce | lwStall_s);
    end
  end

  // Next-state logic for the memory access sequencer and its wait counter.
  always_comb begin
    stateNext_s   = state_r;
    waitCntNext_s = waitCnt_r;
    case (state_r)
      IDLE: begin
        waitCntNext_s = {WCW{1'b0}};
        if (memStall_s) begin
          stateNext_s = WAIT;
        end else begin
          stateNext_s = IDLE;
        end
      end
      WAIT: begin
        if (waitCnt_r != WAIT_MAX) begin
          waitCntNext_s = waitCnt_r + {{(WCW-1){1'b0}}, 1'b1};
        end else begin
          waitCntNext_s = waitCnt_r;
        end
        // A withdrawn request (M flushed or replaced) also ends the wait.
        if (dAck || !memOp_s) begin
          stateNext_s = IDLE;
        end else begin
          stateNext_s = WAIT;
        end
      end
      default: begin
        stateNext_s   = IDLE;
        waitCntNext_s = {WCW{1'b0}};
      end
    endcase
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      waitCnt_r <= {WCW{1'b0}};
      memErr    <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      waitCnt_r <= waitCntNext_s;
      if ((state_r == WAIT) && (waitCntNext_s == WAIT_MAX)) begin
        memErr <= 1'b1;
      end else begin
        memErr <= memErr;
      end
    end
  end

  // Saturating debug count of front-end stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCycles <= {CNT_W{1'b0}};
    end else if (stallF && (stallCycles != {CNT_W{1'b1}})) begin
      stallCycles <= stallCycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stallCycles <= stallCycles;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table-driven combinational vectors through
// a scoreboard queue, plus hand-written memory wait / timeout / reset sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic [1:0] rsltSrce;
  logic       pcSrce, regWrtm, memRdm, memWrtm, regWrtw, dAck;
  logic       dReq, stallF, stallD, stallE, stallM, flushD, flushE, flushW, memErr;
  logic [1:0] fwdAe, fwdBe;
  logic [7:0] stallCycles;

  int nVec = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MAX_WAIT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e),
    .rde(rde), .rsltSrce(rsltSrce), .pcSrce(pcSrce), .rdm(rdm), .regWrtm(regWrtm),
    .memRdm(memRdm), .memWrtm(memWrtm), .rdw(rdw), .regWrtw(regWrtw), .dAck(dAck),
    .dReq(dReq), .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW), .fwdAe(fwdAe), .fwdBe(fwdBe),
    .memErr(memErr), .stallCycles(stallCycles)
  );

  // {dReq, stallF, stallD, stallE, stallM, flushD, flushE, flushW, fwdAe, fwdBe}
  localparam logic [11:0] O_NONE  = {1'b0, 4'b0000, 3'b000, 2'b00, 2'b00};
  localparam logic [11:0] O_RST   = {1'b0, 4'b0000, 3'b111, 2'b00, 2'b00};
  localparam logic [11:0] O_LW    = {1'b0, 4'b1100, 3'b010, 2'b00, 2'b00};
  localparam logic [11:0] O_BR    = {1'b0, 4'b0000, 3'b110, 2'b00, 2'b00};
  localparam logic [11:0] O_MST   = {1'b1, 4'b1111, 3'b001, 2'b00, 2'b00};
  localparam logic [11:0] O_ACK   = {1'b1, 4'b0000, 3'b000, 2'b00, 2'b00};
  localparam logic [11:0] O_ACKBR = {1'b1, 4'b0000, 3'b110, 2'b00, 2'b00};

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic [1:0] rsltSrce;
    logic       pcSrce;
    logic [4:0] rdm;
    logic       regWrtm, memRdm, memWrtm;
    logic [4:0] rdw;
    logic       regWrtw, dAck;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs[16];
  int          nTbl;
  logic [11:0] sbQ[$];

  function automatic logic [11:0] outs();
    return {dReq, stallF, stallD, stallE, stallM, flushD, flushE, flushW, fwdAe, fwdBe};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clrIn();
    rst = 1'b0; rs1d = 5'd0; rs2d = 5'd0; rs1e = 5'd0; rs2e = 5'd0; rde = 5'd0;
    rsltSrce = 2'b00; pcSrce = 1'b0; rdm = 5'd0; regWrtm = 1'b0; memRdm = 1'b0;
    memWrtm = 1'b0; rdw = 5'd0; regWrtw = 1'b0; dAck = 1'b0;
  endtask

  task automatic applyVec(input vec_t v);
    rst = v.rst; rs1d = v.rs1d; rs2d = v.rs2d; rs1e = v.rs1e; rs2e = v.rs2e;
    rde = v.rde; rsltSrce = v.rsltSrce; pcSrce = v.pcSrce; rdm = v.rdm;
    regWrtm = v.regWrtm; memRdm = v.memRdm; memWrtm = v.memWrtm; rdw = v.rdw;
    regWrtw = v.regWrtw; dAck = v.dAck;
  endtask

  task automatic addVec(input vec_t v);
    vecs[nTbl] = v;
    nTbl++;
  endtask

  task automatic pulseRst();
    @(negedge clk); clrIn(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [7:0] expCnt;
    logic [11:0] e;
    clrIn();
    rst = 1'b1;
    nTbl = 0;

    v = '0; v.rst = 1'b1; v.rs1e = 5'd5; v.rdm = 5'd5; v.regWrtm = 1'b1; v.memRdm = 1'b1;
    v.rsltSrce = 2'b01; v.rde = 5'd3; v.rs1d = 5'd3; v.exp = O_RST; addVec(v);
    v = '0; v.rs1e = 5'd5; v.rdm = 5'd5; v.regWrtm = 1'b1; v.rdw = 5'd5; v.regWrtw = 1'b1;
    v.exp = {1'b0, 4'b0000, 3'b000, 2'b10, 2'b00}; addVec(v);
    v.regWrtm = 1'b0; v.exp = {1'b0, 4'b0000, 3'b000, 2'b01, 2'b00}; addVec(v);
    v.regWrtm = 1'b1; v.rdm = 5'd0; v.rdw = 5'd0; v.rs1e = 5'd0; v.exp = O_NONE; addVec(v);
    v = '0; v.rs1e = 5'd9; v.rs2e = 5'd7; v.rdm = 5'd9; v.regWrtm = 1'b1; v.rdw = 5'd7;
    v.regWrtw = 1'b1; v.exp = {1'b0, 4'b0000, 3'b000, 2'b10, 2'b01}; addVec(v);
    v = '0; v.rs1e = 5'd6; v.rs2e = 5'd6; v.rdw = 5'd6; v.regWrtw = 1'b1; v.rdm = 5'd7;
    v.regWrtm = 1'b1; v.exp = {1'b0, 4'b0000, 3'b000, 2'b01, 2'b01}; addVec(v);
    v = '0; v.rsltSrce = 2'b01; v.rde = 5'd3; v.rs2d = 5'd3; v.exp = O_LW; addVec(v);
    v.rde = 5'd0; v.rs2d = 5'd0; v.exp = O_NONE; addVec(v);
    v = '0; v.rsltSrce = 2'b10; v.rde = 5'd3; v.rs1d = 5'd3; v.exp = O_NONE; addVec(v);
    v = '0; v.pcSrce = 1'b1; v.exp = O_BR; addVec(v);
    v.rsltSrce = 2'b01; v.rde = 5'd4; v.rs1d = 5'd4; v.exp = O_BR; addVec(v);
    v = '0; v.memRdm = 1'b1; v.dAck = 1'b1; v.exp = O_ACK; addVec(v);
    v = '0; v.memWrtm = 1'b1; v.dAck = 1'b1; v.pcSrce = 1'b1; v.exp = O_ACKBR; addVec(v);

    expCnt = 8'd0;
    for (int i = 0; i < nTbl; i++) begin
      @(negedge clk);
      applyVec(vecs[i]);
      sbQ.push_back(vecs[i].exp);
      #1;
      e = sbQ.pop_front();
      chk($sformatf("tbl%0d_outs", i), 32'(outs()), 32'(e));
      chk($sformatf("tbl%0d_cnt", i), 32'(stallCycles), 32'(expCnt));
      if (vecs[i].rst) expCnt = 8'd0;
      else if (e[10]) expCnt = expCnt + 8'd1;
    end

    // Memory wait of 3 cycles, then the same with a frozen branch in E.
    pulseRst();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk); clrIn(); memRdm = 1'b1; pcSrce = p[0];
        #1; chk($sformatf("wait%0d_%0d", p, k), 32'(outs()), 32'(O_MST));
      end
      @(negedge clk); dAck = 1'b1;
      #1; chk($sformatf("ack%0d", p), 32'(outs()), 32'((p == 0) ? O_ACK : O_ACKBR));
      @(negedge clk); clrIn(); dAck = 1'b1;
      #1; chk($sformatf("idle%0d", p), 32'(outs()), 32'(O_NONE));
      chk($sformatf("cnt%0d", p), 32'(stallCycles), 32'(3 * (p + 1)));
      chk($sformatf("noerr%0d", p), 32'(memErr), 32'd0);
    end

    // Timeout: 6 cycles without ack, MAX_WAIT = 4.
    pulseRst();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); clrIn(); memRdm = 1'b1;
      #1; chk($sformatf("to_outs%0d", k), 32'(outs()), 32'(O_MST));
      chk($sformatf("to_err%0d", k), 32'(memErr), 32'((k >= 5) ? 1 : 0));
    end
    @(negedge clk); dAck = 1'b1;
    #1; chk("to_ack", 32'(outs()), 32'(O_ACK));
    chk("to_errack", 32'(memErr), 32'd1);
    @(negedge clk); clrIn();
    #1; chk("to_errhold", 32'(memErr), 32'd1);
    chk("to_cnt", 32'(stallCycles), 32'd6);
    @(negedge clk); rst = 1'b1;
    #1; chk("to_rstouts", 32'(outs()), 32'(O_RST));
    @(negedge clk); rst = 1'b0;
    #1; chk("to_errclr", 32'(memErr), 32'd0);
    chk("to_cntclr", 32'(stallCycles), 32'd0);

    // Reset pulsed in the second cycle of a wait.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); clrIn(); memRdm = 1'b1;
    end
    @(negedge clk); rst = 1'b1;
    #1; chk("rw_rstouts", 32'(outs()), 32'(O_RST));
    @(negedge clk); clrIn();
    #1; chk("rw_outs", 32'(outs()), 32'(O_NONE));
    chk("rw_err", 32'(memErr), 32'd0);
    chk("rw_cnt", 32'(stallCycles), 32'd0);

    // Saturation of the 8-bit stall counter under a held load-use stall.
    pulseRst();
    for (int k = 0; k < 260; k++) begin
      @(negedge clk); clrIn(); rsltSrce = 2'b01; rde = 5'd3; rs1d = 5'd3;
      #1;
      if (k == 254) chk("sat_below", 32'(stallCycles), 32'd254);
      if (k == 259) chk("sat_top", 32'(stallCycles), 32'd255);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline controller for the 5-stage in-order RISC-V core. It generates stall, flush and forwarding controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also sequences the M-stage data-memory access over a req/ack handshake, freezing the pipeline while memory is slow. It keeps a sticky memory-timeout flag and a saturating stall-cycle counter for debug.

## Interface
Parameters:
- MAX_WAIT, 16: wait cycles without ack after which memErr is set.
- CNT_W, 32: width of stallCycles.

Ports (clock and reset first):
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rs1d, rs2d  in  5  source registers of the instruction in D
- rs1e, rs2e  in  5  source registers of the instruction in E
- rde  in  5  destination register of the instruction in E
- rsltSrce  in  2  result source in E; 2'b01 marks a load
- pcSrce  in  1  branch/jump taken, resolved in E
- rdm  in  5  destination register in M
- regWrtm  in  1  M instruction writes the register file
- memRdm, memWrtm  in  1  M instruction is a load / store
- rdw  in  5  destination register in W
- regWrtw  in  1  W instruction writes the register file
- dAck  in  1  data memory completes the access this cycle
- dReq  out  1  data memory request, held until dAck
- stallF, stallD, stallE, stallM  out  1  hold PC / IF-ID / ID-EX / EX-MEM
- flushD, flushE, flushW  out  1  load bubble into IF-ID / ID-EX / MEM-WB
- fwdAe, fwdBe  out  2  ALU operand select: 00 regfile, 01 W result, 10 M ALU result
- memErr  out  1  sticky: an access waited MAX_WAIT cycles
- stallCycles  out  CNT_W  saturating count of cycles with stallF=1

## Operation
- Forwarding is combinational, per operand X in {A,B}, srcX = rs1e/rs2e:
  - 10 if regWrtm & rdm!=0 & rdm==srcX.
  - Else 01 if regWrtw & rdw!=0 & rdw==srcX.
  - Else 00. M has priority over W.
- Load-use: lwStall = (rsltSrce==2'b01) & rde!=0 & (rde==rs1d | rde==rs2d).
  - Asserts stallF, stallD, flushE.
- Branch: pcSrce asserts flushD and flushE. lwStall and pcSrce are mutually exclusive by ISA encoding; if both occur, pcSrce masks lwStall.
- memOp = memRdm | memWrtm. dReq = memOp & !rst, in both states.
- memStall = memOp & !dAck.
  - Asserts stallF, stallD, stallE, stallM and flushW.
  - Overrides lwStall and pcSrce: flushD and flushE are forced to 0, so the frozen E-stage branch or load takes effect on release.
- FSM states: IDLE, WAIT.
  - IDLE → WAIT when memStall.
  - IDLE stays IDLE when memOp & dAck (zero-wait access, no stall).
  - WAIT → IDLE when dAck; stalls drop that same cycle and the pipeline advances.
  - WAIT stays WAIT while !dAck.
- waitCnt:
  - Cleared in IDLE; increments every WAIT cycle, saturating at MAX_WAIT.
  - memErr sets when waitCnt reaches MAX_WAIT and stays set until rst.
  - Timeout does not abort the access: dReq stays high.
- stallCycles increments on each cycle with stallF=1 and saturates at all-ones.

## Timing
- Forwarding, stall, flush and dReq outputs are combinational from inputs and state, with zero latency.
- FSM state, waitCnt, memErr and stallCycles update on the rising edge of clk.
- Reset:
  - State: IDLE, waitCnt=0, memErr=0, stallCycles=0.
  - While rst=1: dReq=0, all stalls=0, flushD=flushE=flushW=1, fwdAe=fwdBe=00.
- Reset mid-WAIT: next cycle the FSM is IDLE with dReq=0. The memory side must tolerate request withdrawal.
- Access latency:
  - dAck in the request cycle: 0 stall cycles.
  - dAck N cycles later: exactly N stall cycles.
- memErr rises on the edge ending the MAX_WAIT-th WAIT cycle.
- dAck with dReq=0 is ignored.

## Test plan
- Forwarding: rs1e=5, rdm=5/regWrtm=1, rdw=5/regWrtw=1 → fwdAe=10. Drop regWrtm → fwdAe=01. Set rdm=rdw=0 → fwdAe=00.
- Load-use: rsltSrce=01, rde=3, rs2d=3 → stallF=stallD=flushE=1 for one cycle, stallCycles +1. Set rde=0 → no stall.
- Branch: pcSrce=1 with no memOp → flushD=flushE=1, stalls 0.
- Memory wait: memRdm=1, dAck low 3 cycles then high → dReq high 4 cycles, stallF..stallM=flushW=1 for exactly 3 cycles. FSM returns to IDLE. Same case with pcSrce=1 → flushD/flushE only on the ack cycle.
- Timeout: MAX_WAIT=4, dAck held low 6 cycles → memErr rises after the 4th WAIT cycle, stays 1 after ack, and clears only on rst.
- Reset mid-WAIT: rst pulsed during cycle 2 of a wait → next cycle dReq=0, state IDLE, memErr=0, stallCycles=0.
